// File: rtl/exec_unit_mc.sv
// exec_unit_mc: handshaked execute stage sitting between decode/register-read
// and writeback/PC logic.
//   Single-cycle ALU, shift, move, branch and jump ops produce results one
//   cycle after acceptance. Byte/word loads and stores (plain, pre-decrement,
//   post-increment) run as a request/acknowledge transaction to data memory.
// Ports:
//   clock, reset_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready       op handshake; in_ready is high only in IDLE
//   opcode,dest,src1,imm    decoded op fields; op_a/op_b/op_d register values
//   pc_in                   PC of the op (branch base and link value)
//   wb1_*                   result writeback (ALU result, load data, link)
//   wb2_*                   pointer-update writeback for pre-dec/post-inc
//   mem_*                   data-memory request held until mem_ack
//   pc_load/pc_target       one-cycle PC redirect
//   illegal                 one-cycle pulse for an unknown opcode
module exec_unit_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int REG_AW     = 6,
  parameter int MEM_AW     = 16,
  parameter int PC_WIDTH   = 20,
  parameter int IMM_WIDTH  = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [REG_AW-1:0]     dest,
  input  logic [REG_AW-1:0]     src1,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic [DATA_WIDTH-1:0] op_d,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [PC_WIDTH-1:0]   pc_in,
  output logic                  wb1_en,
  output logic [REG_AW-1:0]     wb1_addr,
  output logic [DATA_WIDTH-1:0] wb1_data,
  output logic                  wb2_en,
  output logic [REG_AW-1:0]     wb2_addr,
  output logic [DATA_WIDTH-1:0] wb2_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_word,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [15:0]           mem_rdata,
  output logic                  pc_load,
  output logic [PC_WIDTH-1:0]   pc_target,
  output logic                  illegal
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] DW_C = DATA_WIDTH'(DATA_WIDTH);

  typedef enum logic [0:0] {IDLE = 1'b0, MEM = 1'b1} state_e;

  state_e state_q, state_d;

  logic                  wb1_en_q, wb1_en_d, wb2_en_q, wb2_en_d;
  logic [REG_AW-1:0]     wb1_addr_q, wb1_addr_d, wb2_addr_q, wb2_addr_d;
  logic [DATA_WIDTH-1:0] wb1_data_q, wb1_data_d, wb2_data_q, wb2_data_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic                  mem_word_q, mem_word_d;
  logic [MEM_AW-1:0]     mem_addr_q, mem_addr_d;
  logic [15:0]           mem_wdata_q, mem_wdata_d;
  logic                  pc_load_q, pc_load_d, illegal_q, illegal_d;
  logic [PC_WIDTH-1:0]   pc_target_q, pc_target_d;
  // pointer writeback owed at the end of the current memory transaction
  logic                  pend_wb2_q, pend_wb2_d;

  logic                  accept_s, is_mem_s, cond_s;
  logic [DATA_WIDTH-1:0] imm_z_s, b_s, alu_s, sz_s, ea_s, ptr_s, link_s;
  logic [PC_WIDTH-1:0]   br_tgt_s, jmp_tgt_s;

  // Shift with saturation: amounts >= DATA_WIDTH give 0, or sign fill for asr.
  // kind: 0 = asr, 1 = lsl, 2 = lsr.
  function automatic logic [DATA_WIDTH-1:0] shift_f(
    input logic [DATA_WIDTH-1:0] v,
    input logic [DATA_WIDTH-1:0] amt,
    input logic [1:0]            kind
  );
    logic [DATA_WIDTH-1:0] r;
    if (amt >= DW_C) begin
      r = (kind == 2'd0) ? {DATA_WIDTH{v[DATA_WIDTH-1]}} : {DATA_WIDTH{1'b0}};
    end else begin
      case (kind)
        2'd0:    r = DATA_WIDTH'($signed(v) >>> amt[SHW-1:0]);
        2'd1:    r = v << amt[SHW-1:0];
        default: r = v >> amt[SHW-1:0];
      endcase
    end
    return r;
  endfunction

  // Register-content compare: 0 eq, 1 ne, 2 slt, 3 sgt, 4 ult, 5 ugt.
  function automatic logic cond_f(
    input logic [2:0]            sel,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic t;
    case (sel)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd2:    t = ($signed(a) < $signed(b));
      3'd3:    t = ($signed(a) > $signed(b));
      3'd4:    t = (a < b);
      3'd5:    t = (a > b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  assign in_ready = (state_q == IDLE);
  assign accept_s = in_valid & in_ready;
  // Memory ops occupy 16..31 except the xx11 codes (19, 23, 27, 31).
  assign is_mem_s = (opcode[5:4] == 2'b01) && (opcode[1:0] != 2'b11);

  // Operand preparation and all single-cycle results.
  always_comb begin
    imm_z_s   = DATA_WIDTH'(imm);
    b_s       = (opcode >= 6'd10) ? imm_z_s : op_b;
    sz_s      = opcode[2] ? DATA_WIDTH'(2'd2) : DATA_WIDTH'(2'd1);
    // pre-decrement moves the pointer first and addresses from the new value
    ptr_s     = (opcode[1:0] == 2'd1) ? (op_a - sz_s) : (op_a + sz_s);
    ea_s      = ((opcode[1:0] == 2'd1) ? ptr_s : op_a) + imm_z_s;
    link_s    = DATA_WIDTH'(pc_in + PC_WIDTH'(1'b1));
    br_tgt_s  = pc_in + PC_WIDTH'($signed(imm));
    jmp_tgt_s = PC_WIDTH'(op_d);
    // branch (34..39) and jump (42..47) conditions share the low opcode bits
    cond_s    = cond_f(3'(opcode[2:0] - 3'd2), op_a, op_b);
    case (opcode)
      6'd1, 6'd10: alu_s = op_a + b_s;
      6'd2, 6'd11: alu_s = op_a - b_s;
      6'd3:        alu_s = op_a & op_b;
      6'd4:        alu_s = op_a | op_b;
      6'd5:        alu_s = op_a ^ op_b;
      6'd6, 6'd12: alu_s = shift_f(op_a, b_s, 2'd0);
      6'd7, 6'd13: alu_s = shift_f(op_a, b_s, 2'd1);
      6'd8, 6'd14: alu_s = shift_f(op_a, b_s, 2'd2);
      6'd9:        alu_s = op_a;
      6'd15:       alu_s = imm_z_s;
      default:     alu_s = {DATA_WIDTH{1'b0}};
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> MEM on a memory op, MEM -> IDLE on mem_ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s && is_mem_s) begin
          state_d = MEM;
        end else begin
          state_d = IDLE;
        end
      end
      MEM: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else begin
          state_d = MEM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values. Pulses default low; data fields hold their value.
  always_comb begin
    wb1_en_d    = 1'b0;
    wb1_addr_d  = wb1_addr_q;
    wb1_data_d  = wb1_data_q;
    wb2_en_d    = 1'b0;
    wb2_addr_d  = wb2_addr_q;
    wb2_data_d  = wb2_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_word_d  = mem_word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target_q;
    illegal_d   = 1'b0;
    pend_wb2_d  = pend_wb2_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          case (opcode) inside
            6'd0: begin
            end
            [6'd1:6'd15]: begin
              wb1_en_d   = 1'b1;
              wb1_addr_d = dest;
              wb1_data_d = alu_s;
            end
            [6'd16:6'd31]: begin
              if (is_mem_s) begin
                mem_req_d   = 1'b1;
                mem_we_d    = opcode[3];
                mem_word_d  = opcode[2];
                mem_addr_d  = MEM_AW'(ea_s);
                mem_wdata_d = opcode[2] ? op_b[15:0] : {8'h00, op_b[7:0]};
                // writeback addresses/pointer value are staged now, pulsed on ack
                wb1_addr_d  = dest;
                wb2_addr_d  = src1;
                wb2_data_d  = ptr_s;
                // a load into its own pointer register keeps the loaded data
                pend_wb2_d  = (opcode[1:0] != 2'd0) && !(!opcode[3] && (dest == src1));
              end else begin
                illegal_d = 1'b1;
              end
            end
            6'd32, 6'd33: begin
              pc_load_d   = 1'b1;
              pc_target_d = br_tgt_s;
              wb1_en_d    = (opcode == 6'd33);
              wb1_addr_d  = dest;
              wb1_data_d  = link_s;
            end
            [6'd34:6'd39]: begin
              pc_load_d   = cond_s;
              pc_target_d = br_tgt_s;
            end
            6'd40, 6'd41: begin
              pc_load_d   = 1'b1;
              pc_target_d = jmp_tgt_s;
              wb1_en_d    = (opcode == 6'd41);
              wb1_addr_d  = src1;
              wb1_data_d  = link_s;
            end
            [6'd42:6'd47]: begin
              pc_load_d   = cond_s;
              pc_target_d = jmp_tgt_s;
            end
            default: illegal_d = 1'b1;
          endcase
        end else begin
        end
      end
      MEM: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          wb1_en_d   = ~mem_we_q;
          wb1_data_d = mem_word_q ? DATA_WIDTH'(mem_rdata) : DATA_WIDTH'(mem_rdata[7:0]);
          wb2_en_d   = pend_wb2_q;
          pend_wb2_d = 1'b0;
        end else begin
        end
      end
      default: begin
      end
    endcase
  end

  // Output and transaction registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wb1_en_q    <= 1'b0;
      wb1_addr_q  <= {REG_AW{1'b0}};
      wb1_data_q  <= {DATA_WIDTH{1'b0}};
      wb2_en_q    <= 1'b0;
      wb2_addr_q  <= {REG_AW{1'b0}};
      wb2_data_q  <= {DATA_WIDTH{1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_word_q  <= 1'b0;
      mem_addr_q  <= {MEM_AW{1'b0}};
      mem_wdata_q <= 16'h0000;
      pc_load_q   <= 1'b0;
      pc_target_q <= {PC_WIDTH{1'b0}};
      illegal_q   <= 1'b0;
      pend_wb2_q  <= 1'b0;
    end else begin
      wb1_en_q    <= wb1_en_d;
      wb1_addr_q  <= wb1_addr_d;
      wb1_data_q  <= wb1_data_d;
      wb2_en_q    <= wb2_en_d;
      wb2_addr_q  <= wb2_addr_d;
      wb2_data_q  <= wb2_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_word_q  <= mem_word_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pc_load_q   <= pc_load_d;
      pc_target_q <= pc_target_d;
      illegal_q   <= illegal_d;
      pend_wb2_q  <= pend_wb2_d;
    end
  end

  assign wb1_en    = wb1_en_q;
  assign wb1_addr  = wb1_addr_q;
  assign wb1_data  = wb1_data_q;
  assign wb2_en    = wb2_en_q;
  assign wb2_addr  = wb2_addr_q;
  assign wb2_data  = wb2_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_word  = mem_word_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc_load   = pc_load_q;
  assign pc_target = pc_target_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Self-checking bench for exec_unit_mc (default parameters): directed cases
// plus randomized ops checked against a behavioural model of the op rules.
module tb_exec_unit_mc;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  dest = 6'd0, src1 = 6'd0;
  logic [15:0] op_a = 16'h0, op_b = 16'h0, op_d = 16'h0;
  logic [8:0]  imm = 9'h0;
  logic [19:0] pc_in = 20'h0;
  logic        wb1_en, wb2_en, mem_req, mem_we, mem_word, pc_load, illegal;
  logic [5:0]  wb1_addr, wb2_addr;
  logic [15:0] wb1_data, wb2_data, mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [19:0] pc_target;

  exec_unit_mc dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .dest(dest), .src1(src1), .op_a(op_a), .op_b(op_b),
    .op_d(op_d), .imm(imm), .pc_in(pc_in),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .wb2_en(wb2_en), .wb2_addr(wb2_addr), .wb2_data(wb2_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_word(mem_word),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_target(pc_target),
    .illegal(illegal)
  );

  always #5 clock = ~clock;

  int check_cnt = 0;
  int fail_cnt  = 0;

  // expected values produced by the model
  int e_wb1_en, e_wb1_addr, e_wb1_data, e_wb2_en, e_wb2_addr, e_wb2_data;
  int e_pc_load, e_tgt, e_illegal, e_we, e_word, e_addr, e_wdata;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sx16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int is_mem(input int op);
    return int'(op >= 16 && op <= 30 && (op % 4) != 3);
  endfunction

  function automatic int cmp(input int k, input int a, input int b);
    case (k)
      0: return int'(a == b);
      1: return int'(a != b);
      2: return int'(sx16(a) < sx16(b));
      3: return int'(sx16(a) > sx16(b));
      4: return int'(a < b);
      5: return int'(a > b);
      default: return 0;
    endcase
  endfunction

  // Behavioural reference: what each opcode should do, in plain arithmetic.
  function automatic void model(input int op, input int dst, input int s1, input int a,
                                input int b, input int d, input int im, input int pc, input int rd);
    int x, sh, r, simm, sz, ld;
    e_wb1_en = 0; e_wb1_addr = 0; e_wb1_data = 0; e_wb2_en = 0; e_wb2_addr = 0;
    e_wb2_data = 0; e_pc_load = 0; e_tgt = 0; e_illegal = 0; e_we = 0; e_word = 0;
    e_addr = 0; e_wdata = 0;
    x = (op >= 10) ? im : b;
    sh = (x > 31) ? 31 : x;
    simm = (im >= 256) ? im - 512 : im;
    r = 0;
    case (op)
      1, 10: r = a + x;
      2, 11: r = a - x;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6, 12: r = (x >= 16) ? ((a >= 32768) ? -1 : 0) : (sx16(a) >>> sh);
      7, 13: r = (x >= 16) ? 0 : (a << sh);
      8, 14: r = (x >= 16) ? 0 : (a >> sh);
      9: r = a;
      15: r = im;
      default: r = 0;
    endcase
    if (op >= 1 && op <= 15) begin
      e_wb1_en = 1; e_wb1_addr = dst; e_wb1_data = r & 'hFFFF;
    end
    if (op >= 32 && op <= 39) begin
      e_pc_load = (op <= 33) ? 1 : cmp(op - 34, a, b);
      e_tgt = (pc + simm) & 'hFFFFF;
      if (op == 33) begin e_wb1_en = 1; e_wb1_addr = dst; e_wb1_data = (pc + 1) & 'hFFFF; end
    end
    if (op >= 40 && op <= 47) begin
      e_pc_load = (op <= 41) ? 1 : cmp(op - 42, a, b);
      e_tgt = d;
      if (op == 41) begin e_wb1_en = 1; e_wb1_addr = s1; e_wb1_data = (pc + 1) & 'hFFFF; end
    end
    if (is_mem(op) != 0) begin
      e_word = int'((op % 8) >= 4);
      e_we = int'(op >= 24);
      sz = (e_word != 0) ? 2 : 1;
      e_addr = (((op % 4) == 1 ? a - sz : a) + im) & 'hFFFF;
      e_wdata = b & ((e_word != 0) ? 'hFFFF : 'hFF);
      ld = 1 - e_we;
      e_wb1_en = ld; e_wb1_addr = dst;
      e_wb1_data = (e_word != 0) ? rd : (rd & 'hFF);
      e_wb2_addr = s1;
      e_wb2_data = (((op % 4) == 1) ? a - sz : a + sz) & 'hFFFF;
      e_wb2_en = int'((op % 4) != 0 && !(ld == 1 && dst == s1));
    end
    e_illegal = int'(op == 19 || op == 23 || op == 27 || op == 31 || op >= 48);
  endfunction

  task automatic drive(input int op, input int dst, input int s1, input int a,
                       input int b, input int d, input int im, input int pc);
    opcode = 6'(op); dest = 6'(dst); src1 = 6'(s1); op_a = 16'(a); op_b = 16'(b);
    op_d = 16'(d); imm = 9'(im); pc_in = 20'(pc);
  endtask

  // Single-cycle op: issue, then check the registered results one edge later.
  task automatic do_single(input int op, input int dst, input int s1, input int a,
                           input int b, input int d, input int im, input int pc);
    model(op, dst, s1, a, b, d, im, pc, 0);
    check_val("ready_pre", 32'(in_ready), 32'd1);
    drive(op, dst, s1, a, b, d, im, pc);
    in_valid = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));   // stray ack in IDLE must be ignored
    mem_rdata = 16'($urandom);
    @(posedge clock); #1;
    mem_ack = 1'b0;
    in_valid = 1'b0;
    check_val($sformatf("wb1_en op%0d", op), 32'(wb1_en), e_wb1_en);
    if (e_wb1_en != 0) begin
      check_val($sformatf("wb1_addr op%0d", op), 32'(wb1_addr), e_wb1_addr);
      check_val($sformatf("wb1_data op%0d", op), 32'(wb1_data), e_wb1_data);
    end
    check_val($sformatf("pc_load op%0d", op), 32'(pc_load), e_pc_load);
    if (e_pc_load != 0) check_val($sformatf("pc_target op%0d", op), 32'(pc_target), e_tgt);
    check_val($sformatf("illegal op%0d", op), 32'(illegal), e_illegal);
    check_val($sformatf("wb2_en op%0d", op), 32'(wb2_en), 32'd0);
    check_val($sformatf("mem_req op%0d", op), 32'(mem_req), 32'd0);
  endtask

  // Memory op: request held for waits+1 cycles, ack in the last one.
  task automatic do_mem(input int op, input int dst, input int s1, input int a,
                        input int b, input int im, input int waits, input int rd);
    model(op, dst, s1, a, b, 0, im, 0, rd);
    check_val("ready_pre", 32'(in_ready), 32'd1);
    drive(op, dst, s1, a, b, 0, im, 0);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      check_val("mem_req", 32'(mem_req), 32'd1);
      check_val("mem_addr", 32'(mem_addr), e_addr);
      check_val("mem_we", 32'(mem_we), e_we);
      check_val("mem_word", 32'(mem_word), e_word);
      if (e_we != 0) begin
        if (e_word != 0) check_val("mem_wdata", 32'(mem_wdata), e_wdata);
        else check_val("mem_wdata_lo", 32'(mem_wdata[7:0]), e_wdata);
      end
      check_val("ready_mem", 32'(in_ready), 32'd0);
      check_val("wb_idle", 32'({wb1_en, wb2_en}), 32'd0);
      if (i == waits) begin
        mem_ack = 1'b1;
        mem_rdata = 16'(rd);
      end
      @(posedge clock); #1;
    end
    mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
    check_val("mem_req_drop", 32'(mem_req), 32'd0);
    check_val("ready_post", 32'(in_ready), 32'd1);
    check_val($sformatf("m_wb1_en op%0d", op), 32'(wb1_en), e_wb1_en);
    if (e_wb1_en != 0) begin
      check_val("m_wb1_addr", 32'(wb1_addr), e_wb1_addr);
      check_val("m_wb1_data", 32'(wb1_data), e_wb1_data);
    end
    check_val($sformatf("m_wb2_en op%0d", op), 32'(wb2_en), e_wb2_en);
    if (e_wb2_en != 0) begin
      check_val("m_wb2_addr", 32'(wb2_addr), e_wb2_addr);
      check_val("m_wb2_data", 32'(wb2_data), e_wb2_data);
    end
  endtask

  initial begin
    int op, a, b, dst, s1;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_ready", 32'(in_ready), 32'd1);
    check_val("rst_pulses", 32'({wb1_en, wb2_en, mem_req, mem_we, mem_word, pc_load, illegal}), 32'd0);
    check_val("rst_data", 32'(wb1_data | wb2_data | mem_addr | mem_wdata), 32'd0);
    check_val("rst_addr", 32'({wb1_addr, wb2_addr}), 32'd0);
    check_val("rst_tgt", 32'(pc_target), 32'd0);
    reset_n = 1'b1;

    // add/sub back to back, then shifts
    do_single(1, 3, 4, 'hFFFF, 2, 0, 0, 0);
    check_val("plan_add", 32'(wb1_data), 32'h0001);
    do_single(2, 3, 4, 1, 2, 0, 0, 0);
    check_val("plan_sub", 32'(wb1_data), 32'hFFFF);
    do_single(6, 5, 0, 'h8000, 20, 0, 0, 0);
    check_val("plan_asr", 32'(wb1_data), 32'hFFFF);
    do_single(8, 5, 0, 'h8000, 20, 0, 0, 0);
    check_val("plan_lsr", 32'(wb1_data), 32'h0000);
    do_single(13, 5, 0, 1, 0, 0, 3, 0);
    check_val("plan_lsl", 32'(wb1_data), 32'h0008);

    // memory: post-increment word load, pre-decrement byte store
    do_mem(22, 5, 6, 'h0100, 0, 4, 3, 'hBEEF);
    check_val("plan_ld_wb2", 32'(wb2_data), 32'h0102);
    do_mem(25, 1, 2, 'h0010, 'h12AB, 0, 1, 0);
    check_val("plan_st_wb2", 32'(wb2_data), 32'h000F);
    do_mem(18, 7, 7, 'h0200, 0, 1, 0, 'h1234);   // dest==src1: load wins

    // branches and jumps
    do_single(36, 0, 0, 'hFFFF, 1, 0, 'h1FC, 100);
    check_val("plan_slt_tgt", 32'(pc_target), 32'd96);
    do_single(38, 0, 0, 'hFFFF, 1, 0, 'h1FC, 100);
    do_single(41, 2, 9, 0, 0, 'h0300, 0, 7);
    check_val("plan_jal_link", 32'(wb1_data), 32'd8);
    do_single(19, 1, 1, 5, 5, 0, 0, 0);

    // reset in the middle of a transaction, then a late ack
    drive(20, 3, 4, 'h0040, 0, 0, 0, 0);
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check_val("rstm_req", 32'(mem_req), 32'd1);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    check_val("rstm_drop", 32'(mem_req), 32'd0);
    check_val("rstm_ready", 32'(in_ready), 32'd1);
    check_val("rstm_nowb", 32'({wb1_en, wb2_en}), 32'd0);
    mem_ack = 1'b1;
    mem_rdata = 16'hA5A5;
    repeat (2) begin
      @(posedge clock); #1;
      check_val("late_ack", 32'({wb1_en, wb2_en, mem_req}), 32'd0);
      check_val("late_ready", 32'(in_ready), 32'd1);
    end
    mem_ack = 1'b0;

    // randomized ops
    for (int n = 0; n < 400; n++) begin
      op  = $urandom_range(0, 63);
      a   = ($urandom_range(0, 3) == 0) ? 'h8000 + $urandom_range(0, 3) : $urandom_range(0, 65535);
      b   = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 20) : $urandom_range(0, 65535);
      if ($urandom_range(0, 5) == 0) b = a;
      dst = $urandom_range(0, 63);
      s1  = ($urandom_range(0, 4) == 0) ? dst : $urandom_range(0, 63);
      if (is_mem(op) != 0)
        do_mem(op, dst, s1, a, b, $urandom_range(0, 511), $urandom_range(0, 3), $urandom_range(0, 65535));
      else
        do_single(op, dst, s1, a, b, $urandom_range(0, 65535), $urandom_range(0, 511),
                  $urandom_range(0, 1048575));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
    $finish;
  end

endmodule
